// File: rtl/maze_pkg.sv
// Shared types and constants for the maze actor: FSM states, probe slot
// ordering and switch bit positions.
package maze_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PROBE  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Probe slots in presentation order: two per direction, leading edge corners.
    localparam logic [2:0] PRB_L_TOP = 3'd0;
    localparam logic [2:0] PRB_L_BOT = 3'd1;
    localparam logic [2:0] PRB_R_TOP = 3'd2;
    localparam logic [2:0] PRB_R_BOT = 3'd3;
    localparam logic [2:0] PRB_U_LFT = 3'd4;
    localparam logic [2:0] PRB_U_RGT = 3'd5;
    localparam logic [2:0] PRB_D_LFT = 3'd6;
    localparam logic [2:0] PRB_D_RGT = 3'd7;

    localparam int SW_LEFT  = 0;
    localparam int SW_RIGHT = 1;
    localparam int SW_UP    = 2;
    localparam int SW_DOWN  = 3;

    // Returns {positive, negative} request; opposing presses cancel.
    function automatic logic [1:0] axis_req(input logic neg, input logic pos);
        return {pos & ~neg, neg & ~pos};
    endfunction

endpackage

// File: rtl/maze_probe_gen.sv
// Maps a probe slot index and the sprite top-left position to the playfield
// coordinate that must be looked up for that slot.
module maze_probe_gen
    import maze_pkg::*;
#(
    parameter int SPR_W = 11,
    parameter int SPR_H = 11,
    parameter int SPEED = 1,
    parameter int POS_W = 9
) (
    input  logic [2:0]       idx_i,
    input  logic [POS_W-1:0] pos_x_i,
    input  logic [POS_W-1:0] pos_y_i,
    output logic [POS_W-1:0] probe_x_o,
    output logic [POS_W-1:0] probe_y_o
);

    localparam logic [POS_W-1:0] SPD   = POS_W'(SPEED);
    localparam logic [POS_W-1:0] W_M1  = POS_W'(SPR_W - 1);
    localparam logic [POS_W-1:0] H_M1  = POS_W'(SPR_H - 1);

    // Coordinates wrap modulo 2^POS_W; out-of-range moves are rejected by the caller.
    always_comb begin
        probe_x_o = pos_x_i;
        probe_y_o = pos_y_i;
        case (idx_i)
            PRB_L_TOP: begin probe_x_o = pos_x_i - SPD;        probe_y_o = pos_y_i;               end
            PRB_L_BOT: begin probe_x_o = pos_x_i - SPD;        probe_y_o = pos_y_i + H_M1;        end
            PRB_R_TOP: begin probe_x_o = pos_x_i + W_M1 + SPD; probe_y_o = pos_y_i;               end
            PRB_R_BOT: begin probe_x_o = pos_x_i + W_M1 + SPD; probe_y_o = pos_y_i + H_M1;        end
            PRB_U_LFT: begin probe_x_o = pos_x_i;              probe_y_o = pos_y_i - SPD;         end
            PRB_U_RGT: begin probe_x_o = pos_x_i + W_M1;       probe_y_o = pos_y_i - SPD;         end
            PRB_D_LFT: begin probe_x_o = pos_x_i;              probe_y_o = pos_y_i + H_M1 + SPD;  end
            PRB_D_RGT: begin probe_x_o = pos_x_i + W_M1;       probe_y_o = pos_y_i + H_M1 + SPD;  end
            default:   begin probe_x_o = pos_x_i;              probe_y_o = pos_y_i;               end
        endcase
    end

endmodule

// File: rtl/maze_actor.sv
// Maze sprite mover: per frame, probes eight wall points then commits a move.
// Define MAZE_ACTOR_DIAG_EN to let X and Y moves commit in the same frame.
module maze_actor
    import maze_pkg::*;
#(
    parameter int SPR_W   = 11,
    parameter int SPR_H   = 11,
    parameter int SPEED   = 1,
    parameter int START_X = 220,
    parameter int START_Y = 30,
    parameter int POS_W   = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic [3:0]       switches,
    input  logic             caught,
    output logic [POS_W-1:0] probe_x,
    output logic [POS_W-1:0] probe_y,
    input  logic             probe_wall,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic             busy,
    output logic             moved,
    output logic             overrun
);

    localparam logic [POS_W-1:0] SPD    = POS_W'(SPEED);
    localparam logic [POS_W:0]   SPD_EX = (POS_W+1)'(SPEED);
    localparam logic [POS_W:0]   X_LIM  = (POS_W+1)'((2**POS_W) - SPR_W);
    localparam logic [POS_W:0]   Y_LIM  = (POS_W+1)'((2**POS_W) - SPR_H);
    localparam logic [POS_W-1:0] X0     = POS_W'(START_X);
    localparam logic [POS_W-1:0] Y0     = POS_W'(START_Y);

    state_e           state_q, state_d;
    logic [2:0]       idx_q;
    logic [3:0]       sw_q;
    logic [7:0]       blocked_q;
    logic [POS_W-1:0] pos_x_q, pos_y_q;
    logic             moved_q, overrun_q;

    logic             start, commit_en;
    logic [2:0]       probe_idx;
    logic [1:0]       x_req, y_req;
    logic             x_neg_ok, x_pos_ok, y_neg_ok, y_pos_ok;
    logic             x_take, y_take;
    logic [POS_W-1:0] pos_x_d, pos_y_d;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state; caught overrides everything, including a fresh tick
    always_comb begin
        state_d = state_q;
        if (caught) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (frame_tick) state_d = ST_PROBE;
                ST_PROBE:  if (idx_q == PRB_D_RGT) state_d = ST_COMMIT;
                ST_COMMIT: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        busy      = (state_q != ST_IDLE);
        start     = (state_q == ST_IDLE) && frame_tick && !caught;
        commit_en = (state_q == ST_COMMIT) && !caught;
        probe_idx = (state_q == ST_PROBE) ? idx_q : PRB_L_TOP;
    end

    maze_probe_gen #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .SPEED (SPEED),
        .POS_W (POS_W)
    ) u_probe_gen (
        .idx_i     (probe_idx),
        .pos_x_i   (pos_x_q),
        .pos_y_i   (pos_y_q),
        .probe_x_o (probe_x),
        .probe_y_o (probe_y)
    );

    // Move legality: direction request, both leading corners clear, and inside the field
    always_comb begin
        x_req    = axis_req(sw_q[SW_LEFT], sw_q[SW_RIGHT]);
        y_req    = axis_req(sw_q[SW_UP],   sw_q[SW_DOWN]);
        x_neg_ok = x_req[0] && !blocked_q[PRB_L_TOP] && !blocked_q[PRB_L_BOT]
                   && (pos_x_q >= SPD);
        x_pos_ok = x_req[1] && !blocked_q[PRB_R_TOP] && !blocked_q[PRB_R_BOT]
                   && (({1'b0, pos_x_q} + SPD_EX) <= X_LIM);
        y_neg_ok = y_req[0] && !blocked_q[PRB_U_LFT] && !blocked_q[PRB_U_RGT]
                   && (pos_y_q >= SPD);
        y_pos_ok = y_req[1] && !blocked_q[PRB_D_LFT] && !blocked_q[PRB_D_RGT]
                   && (({1'b0, pos_y_q} + SPD_EX) <= Y_LIM);
        x_take   = x_neg_ok || x_pos_ok;
`ifdef MAZE_ACTOR_DIAG_EN
        y_take   = y_neg_ok || y_pos_ok;
`else
        y_take   = (y_neg_ok || y_pos_ok) && !x_take;
`endif
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        if (x_neg_ok)                pos_x_d = pos_x_q - SPD;
        else if (x_pos_ok)           pos_x_d = pos_x_q + SPD;
        if (y_take && y_neg_ok)      pos_y_d = pos_y_q - SPD;
        else if (y_take && y_pos_ok) pos_y_d = pos_y_q + SPD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q     <= '0;
            sw_q      <= '0;
            blocked_q <= '0;
            pos_x_q   <= X0;
            pos_y_q   <= Y0;
            moved_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            moved_q <= 1'b0;
            if (frame_tick && busy) overrun_q <= 1'b1;
            if (caught) begin
                idx_q   <= '0;
                pos_x_q <= X0;
                pos_y_q <= Y0;
            end else begin
                if (start) begin
                    sw_q  <= switches;
                    idx_q <= '0;
                end
                if (state_q == ST_PROBE) begin
                    blocked_q[idx_q] <= probe_wall;
                    idx_q            <= idx_q + 3'd1;
                end
                if (commit_en) begin
                    pos_x_q <= pos_x_d;
                    pos_y_q <= pos_y_d;
                    moved_q <= x_take || y_take;
                end
            end
        end
    end

    assign pos_x   = pos_x_q;
    assign pos_y   = pos_y_q;
    assign moved   = moved_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_maze_actor.sv
// Directed and randomized bench for maze_actor against a rule-level model.
module tb_maze_actor;

    localparam int POS_W = 9;
    localparam int PMAX  = 512;
    localparam int SPR_W = 11;
    localparam int SPR_H = 11;
    localparam int SPEED = 1;
`ifdef MAZE_ACTOR_DIAG_EN
    localparam bit DIAG = 1'b1;
`else
    localparam bit DIAG = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             frame_tick = 1'b0;
    logic [3:0]       switches = 4'd0;
    logic             caught = 1'b0;
    logic [POS_W-1:0] probe_x, probe_y, pos_x, pos_y;
    logic             probe_wall, busy, moved, overrun;

    logic             frame_tick_b = 1'b0;
    logic [3:0]       switches_b = 4'd0;
    logic             probe_wall_b = 1'b0;
    logic [POS_W-1:0] probe_x_b, probe_y_b, pos_x_b, pos_y_b;
    logic             busy_b, moved_b, overrun_b;

    int wall_mode = 0;
    int wall_col  = 0;
    int seed      = 5;
    int n_checks  = 0;
    int n_fail    = 0;
    int mx = 220;
    int my = 30;

    always #5 clk = ~clk;

    function automatic logic wall_at(input int x, input int y, input int mode,
                                     input int col, input int sd);
        case (mode)
            1:       return (x == col);
            2:       return (((x * 31 + y * 17 + sd) % 23) == 0);
            default: return 1'b0;
        endcase
    endfunction

    assign probe_wall = wall_at(int'(probe_x), int'(probe_y), wall_mode, wall_col, seed);

    maze_actor dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .switches(switches),
        .caught(caught), .probe_x(probe_x), .probe_y(probe_y), .probe_wall(probe_wall),
        .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .moved(moved), .overrun(overrun)
    );

    maze_actor #(.SPEED(2), .START_X(1), .START_Y(0)) dut_b (
        .clk(clk), .reset(reset), .frame_tick(frame_tick_b), .switches(switches_b),
        .caught(caught), .probe_x(probe_x_b), .probe_y(probe_y_b), .probe_wall(probe_wall_b),
        .pos_x(pos_x_b), .pos_y(pos_y_b), .busy(busy_b), .moved(moved_b), .overrun(overrun_b)
    );

    function automatic logic w(input int x, input int y);
        return wall_at(((x % PMAX) + PMAX) % PMAX, ((y % PMAX) + PMAX) % PMAX,
                       wall_mode, wall_col, seed);
    endfunction

    function automatic int wrap(input int v);
        return ((v % PMAX) + PMAX) % PMAX;
    endfunction

    function automatic int pt_x(input int k, input int x);
        case (k)
            0, 1:    return wrap(x - SPEED);
            2, 3:    return wrap(x + SPR_W - 1 + SPEED);
            4, 6:    return wrap(x);
            default: return wrap(x + SPR_W - 1);
        endcase
    endfunction

    function automatic int pt_y(input int k, input int y);
        case (k)
            0, 2:    return wrap(y);
            1, 3:    return wrap(y + SPR_H - 1);
            4, 5:    return wrap(y - SPEED);
            default: return wrap(y + SPR_H - 1 + SPEED);
        endcase
    endfunction

    // Expected outcome of one frame from the current model position
    task automatic model_next(input logic [3:0] sw, output int ex, output int ey, output bit emv);
        bit l, r, u, d, xl, xr, yu, yd;
        int dx, dy;
        l  = sw[0] && !sw[1];
        r  = sw[1] && !sw[0];
        u  = sw[2] && !sw[3];
        d  = sw[3] && !sw[2];
        xl = l && (mx >= SPEED) && !w(mx - SPEED, my) && !w(mx - SPEED, my + SPR_H - 1);
        xr = r && (mx + SPEED <= PMAX - SPR_W)
               && !w(mx + SPR_W - 1 + SPEED, my) && !w(mx + SPR_W - 1 + SPEED, my + SPR_H - 1);
        yu = u && (my >= SPEED) && !w(mx, my - SPEED) && !w(mx + SPR_W - 1, my - SPEED);
        yd = d && (my + SPEED <= PMAX - SPR_H)
               && !w(mx, my + SPR_H - 1 + SPEED) && !w(mx + SPR_W - 1, my + SPR_H - 1 + SPEED);
        dx = xl ? -SPEED : (xr ? SPEED : 0);
        dy = yu ? -SPEED : (yd ? SPEED : 0);
        if (!DIAG && dx != 0) dy = 0;
        ex  = mx + dx;
        ey  = my + dy;
        emv = (dx != 0) || (dy != 0);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full frame with per-cycle checks of probes, latency and the moved pulse
    task automatic do_frame(input logic [3:0] sw);
        int ex, ey;
        bit emv;
        model_next(sw, ex, ey, emv);
        check("idle_probe_x", int'(probe_x), pt_x(0, mx));
        check("idle_probe_y", int'(probe_y), pt_y(0, my));
        frame_tick = 1'b1;
        switches   = sw;
        step();
        frame_tick = 1'b0;
        switches   = 4'($urandom);
        check("busy_start", int'(busy), 1);
        for (int k = 0; k < 8; k++) begin
            check("probe_x", int'(probe_x), pt_x(k, mx));
            check("probe_y", int'(probe_y), pt_y(k, my));
            step();
        end
        check("commit_hold_x", int'(pos_x), mx);
        check("commit_hold_y", int'(pos_y), my);
        check("commit_busy", int'(busy), 1);
        step();
        check("pos_x", int'(pos_x), ex);
        check("pos_y", int'(pos_y), ey);
        check("moved", int'(moved), int'(emv));
        check("busy_end", int'(busy), 0);
        step();
        check("moved_pulse_end", int'(moved), 0);
        mx = ex;
        my = ey;
    endtask

    task automatic frame_b(input logic [3:0] sw, input int ex, input int ey, input int emv);
        frame_tick_b = 1'b1;
        switches_b   = sw;
        step();
        frame_tick_b = 1'b0;
        for (int k = 0; k < 9; k++) step();
        check("b_pos_x", int'(pos_x_b), ex);
        check("b_pos_y", int'(pos_y_b), ey);
        check("b_moved", int'(moved_b), emv);
        step();
    endtask

    initial begin
        int ex, ey;
        bit emv;
        step();
        step();
        check("rst_pos_x", int'(pos_x), 220);
        check("rst_pos_y", int'(pos_y), 30);
        check("rst_busy", int'(busy), 0);
        check("rst_moved", int'(moved), 0);
        check("rst_overrun", int'(overrun), 0);
        reset = 1'b0;
        step();
        check("rst_probe_x", int'(probe_x), 219);
        check("rst_probe_y", int'(probe_y), 30);

        // Wall just left of the sprite blocks the left move
        wall_mode = 1;
        wall_col  = 219;
        do_frame(4'b0001);
        check("blocked_left", int'(dut.blocked_q[1:0]), 3);
        check("wall_pos_x", int'(pos_x), 220);

        wall_mode = 0;
        do_frame(4'b0001);
        check("open_left_x", int'(pos_x), 219);

        // caught in the fourth probe cycle aborts the sequence
        frame_tick = 1'b1;
        switches   = 4'b0001;
        step();
        frame_tick = 1'b0;
        for (int k = 0; k < 3; k++) step();
        caught = 1'b1;
        step();
        caught = 1'b0;
        check("caught_x", int'(pos_x), 220);
        check("caught_y", int'(pos_y), 30);
        check("caught_busy", int'(busy), 0);
        for (int k = 0; k < 8; k++) begin
            check("caught_no_move", int'(moved), 0);
            step();
        end
        check("caught_hold_x", int'(pos_x), 220);
        mx = 220;
        my = 30;

        do_frame(4'b0011);
        do_frame(4'b0101);
        check("diag_y", int'(pos_y), DIAG ? 29 : 30);
        check("overrun_still_0", int'(overrun), 0);

        // Second tick while busy is dropped and flags overrun
        model_next(4'b1000, ex, ey, emv);
        frame_tick = 1'b1;
        switches   = 4'b1000;
        step();
        frame_tick = 1'b0;
        step();
        step();
        frame_tick = 1'b1;
        switches   = 4'b0001;
        step();
        frame_tick = 1'b0;
        check("overrun_set", int'(overrun), 1);
        for (int k = 0; k < 6; k++) step();
        check("ovr_pos_x", int'(pos_x), ex);
        check("ovr_pos_y", int'(pos_y), ey);
        check("ovr_moved", int'(moved), int'(emv));
        step();
        step();
        check("ovr_no_second", int'(busy), 0);
        check("overrun_sticky", int'(overrun), 1);
        mx = ex;
        my = ey;

        // Reset mid-sequence aborts with no commit and clears overrun
        frame_tick = 1'b1;
        switches   = 4'b0010;
        step();
        frame_tick = 1'b0;
        for (int k = 0; k < 4; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_x", int'(pos_x), 220);
        check("midrst_y", int'(pos_y), 30);
        check("midrst_busy", int'(busy), 0);
        check("midrst_overrun", int'(overrun), 0);
        for (int k = 0; k < 8; k++) begin
            check("midrst_no_move", int'(moved), 0);
            step();
        end
        mx = 220;
        my = 30;

        // SPEED=2 instance at the low edges
        frame_b(4'b0001, 1, 0, 0);
        frame_b(4'b0100, 1, 0, 0);
        frame_b(4'b0010, 3, 0, 1);
        frame_b(4'b1000, 3, 2, 1);

        // Randomized frames on a scattered wall map
        wall_mode = 2;
        seed      = int'($urandom_range(0, 22));
        for (int f = 0; f < 40; f++) do_frame(4'($urandom_range(0, 15)));

        // Walk to the left edge, then push against it
        wall_mode = 0;
        for (int f = 0; f < PMAX && mx > 0; f++) do_frame(4'b0001);
        do_frame(4'b0001);
        check("left_floor_x", int'(pos_x), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/maze_actor.md
MAZE_ACTOR -- requirements
Module: maze_actor

Interface
REQ-001 SHALL expose parameter SPR_W, default 11, sprite width in pixels (2..32).
REQ-002 SHALL expose parameter SPR_H, default 11, sprite height in pixels (2..32).
REQ-003 SHALL expose parameter SPEED, default 1, pixels moved per frame per axis (1..7).
REQ-004 SHALL expose parameters START_X / START_Y, defaults 220 / 30, respawn position.
REQ-005 SHALL expose parameter POS_W, default 9, position width in bits.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 frame_tick  in  1  one-cycle pulse per frame that starts an update.
REQ-009 switches  in  4  [0]=left, [1]=right, [2]=up, [3]=down, sampled at frame_tick.
REQ-010 caught  in  1  collision with the opponent; forces respawn.
REQ-011 probe_x, probe_y  out  POS_W  pixel coordinate presented to an external playfield lookup.
REQ-012 probe_wall  in  1  combinational playfield answer for (probe_x, probe_y), valid in the same cycle.
REQ-013 pos_x, pos_y  out  POS_W  current sprite top-left position.
REQ-014 busy  out  1  high while an update sequence is in progress.
REQ-015 moved  out  1  one-cycle pulse when the position changes in COMMIT.
REQ-016 overrun  out  1  sticky; set when frame_tick arrives while busy.

Function
REQ-017 The FSM SHALL have three states, IDLE, PROBE and COMMIT: IDLE->PROBE on frame_tick; PROBE runs 8 cycles, then COMMIT; COMMIT lasts 1 cycle, then IDLE.
REQ-018 Switches SHALL be latched on the frame_tick cycle; changes during PROBE SHALL be ignored.
REQ-019 PROBE index 0..7 SHALL present these points, all computed from the latched position: (x-SPEED,y), (x-SPEED,y+SPR_H-1), (x+SPR_W-1+SPEED,y), (x+SPR_W-1+SPEED,y+SPR_H-1), (x,y-SPEED), (x+SPR_W-1,y-SPEED), (x,y+SPR_H-1+SPEED), (x+SPR_W-1,y+SPR_H-1+SPEED).
REQ-020 probe_wall SHALL be captured into an 8-bit blocked vector at its index.
REQ-021 X axis: left-only with both left probes clear -> x-SPEED; right-only with both right probes clear -> x+SPEED; both or neither pressed, or a blocking probe -> no change.
REQ-022 The Y axis SHALL follow the REQ-021 rules using up/down and probes 4..7.
REQ-023 The new position SHALL be written in COMMIT, so pos_x/pos_y change 10 cycles after the frame_tick cycle.
REQ-024 Arithmetic SHALL be POS_W wide; a move that would go below 0 or above 2^POS_W-SPR_W SHALL be suppressed (no wrap-around).
REQ-025 caught high in any state SHALL load START_X/START_Y, abort any sequence, and enter IDLE next cycle with moved=0; caught takes priority over frame_tick.
REQ-026 A frame_tick while busy SHALL be dropped and SHALL set overrun; overrun clears only on reset.
REQ-027 probe_x/probe_y SHALL hold the probe-0 point while in IDLE.

Reset
REQ-028 On reset: state IDLE, pos_x=START_X, pos_y=START_Y, busy=0, moved=0, overrun=0, blocked=0, latched switches=0.
REQ-029 Reset asserted mid-sequence SHALL abort with no COMMIT.

Configuration
REQ-030 Macro MAZE_ACTOR_DIAG_EN: when defined, X and Y moves both commit in one frame.
REQ-031 When MAZE_ACTOR_DIAG_EN is undefined and both axes have a legal move, only the X move commits and the Y move is discarded.

Structure
REQ-032 Package maze_pkg SHALL hold the state enum, the probe-index constants 0..7 and the switch bit-index constants.
REQ-033 Sub-module maze_probe_gen SHALL hold the combinational mapping from probe index plus position to probe_x/probe_y.

Verification
REQ-034 Open field, switches=0001, pos (220,30), frame_tick -> pos (219,30) at tick+10, moved=1 for 1 cycle.
REQ-035 Wall at the left probes, switches=0001 -> pos unchanged, moved=0, blocked[1:0]=11.
REQ-036 switches=0011 (left+right) -> no X change; switches=0101, open field -> (219,29) with DIAG_EN, (219,30) without.
REQ-037 caught pulsed in PROBE cycle 4 -> pos (220,30) next cycle, no COMMIT, busy=0.
REQ-038 Second frame_tick 3 cycles after the first -> ignored, overrun=1; the first update completes normally.
REQ-039 pos_x=0, switches=0001, no walls -> pos_x stays 0; with SPEED=2, pos_x=1 -> stays 1.
